eriscv_boot_loader: RTL

- Boot-time program loader sitting directly upstream of `eriscv_min_sopc`.
- Accepts a byte stream (from a UART receiver or testbench driver), writes 32-bit words into the instruction memory write port, checks an XOR checksum, then releases the SOPC's `rst`.
- Holds the core in reset until a valid image is loaded. A corrupt image leaves the core in reset, with an error flag set.

---
 rtl/eriscv_boot_loader.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/eriscv_boot_loader.sv
// Boot loader: takes a byte stream (4-byte LE word count N, N*4 payload bytes,
// 1 XOR checksum byte), writes words to instruction memory, then releases the core.
// Latency: memory write registered one cycle after the 4th byte of a word; release/error one edge after the deciding byte.
// Backpressure: rx_ready is registered and high only while collecting the header, the payload or the checksum.
//
// Ports:
//   clk, rst        - clock, asynchronous active-low reset
//   rx_valid/ready  - byte stream handshake, rx_data carries the byte
//   mem_we/addr/wdata - registered instruction-memory write port (word addressed)
//   core_rst        - 1 holds the downstream core in reset
//   boot_done       - image loaded and checksum matched
//   boot_err        - sticky: oversize length or checksum mismatch
module eriscv_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int RST_HOLD   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  core_rst,
  output logic                  boot_done,
  output logic                  boot_err
);

  typedef enum logic [2:0] {
    S_HOLD  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CHECK = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  // Largest legal word count, widened so 2^ADDR_WIDTH itself is representable.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_WIDTH;

  state_t                state, state_nxt;
  logic [7:0]            hold_cnt;
  logic [1:0]            byte_cnt;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [31:0]           len;
  logic [7:0]            csum;
  logic [23:0]           word_sh;

  logic                  accept;
  logic [31:0]           len_full;
  logic [31:0]           word_next;

  assign accept    = rx_valid && rx_ready;
  // Bytes shift in from the top, so after four bytes byte 0 sits in [7:0].
  assign len_full  = {rx_data, len[31:8]};
  assign word_next = 32'(word_cnt) + 32'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_HOLD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HOLD: begin
        if (hold_cnt == 8'(RST_HOLD - 1)) state_nxt = S_LEN;
      end
      S_LEN: begin
        if (accept && byte_cnt == 2'd3) begin
          if ({1'b0, len_full} > MAX_WORDS) state_nxt = S_ERROR;
          else if (len_full == 32'd0)       state_nxt = S_CHECK;
          else                              state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_cnt == 2'd3 && word_next == len) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (accept) state_nxt = (rx_data == csum) ? S_RUN : S_ERROR;
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_cnt  <= '0;
      byte_cnt  <= '0;
      word_cnt  <= '0;
      len       <= '0;
      csum      <= '0;
      word_sh   <= '0;
      rx_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      core_rst  <= 1'b1;
      boot_done <= 1'b0;
      boot_err  <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      // Status outputs follow the next state so they change on the deciding edge.
      rx_ready  <= (state_nxt == S_LEN) || (state_nxt == S_DATA) || (state_nxt == S_CHECK);
      core_rst  <= (state_nxt != S_RUN);
      boot_done <= (state_nxt == S_RUN);
      boot_err  <= (state_nxt == S_ERROR);
      case (state)
        S_HOLD: begin
          hold_cnt <= hold_cnt + 8'd1;
          byte_cnt <= '0;
          word_cnt <= '0;
          len      <= '0;
          csum     <= '0;
        end
        S_LEN: begin
          if (accept) begin
            len      <= len_full;
            byte_cnt <= byte_cnt + 2'd1;
          end
        end
        S_DATA: begin
          if (accept) begin
            csum     <= csum ^ rx_data;
            word_sh  <= {rx_data, word_sh[23:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
              mem_wdata <= {rx_data, word_sh};
              word_cnt  <= word_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
